// File: rtl/pipeline_sequencer.sv
// Execution-control and hazard sequencer for a 5-stage MIPS pipeline.
// Handles run/step/halt control, load-use stalls, branch flushes, HALT drain and a saturating cycle counter.
module pipeline_sequencer #(
    parameter int RA_W         = 5,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    input  logic             halt_instr,
    input  logic             id_ex_MemRead,
    input  logic [RA_W-1:0]  id_ex_rt,
    input  logic [RA_W-1:0]  if_id_rs,
    input  logic [RA_W-1:0]  if_id_rt,
    input  logic             branch_taken,
    output logic             pipe_en,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             step_done,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    state_t        state_q;
    logic [DW-1:0] drain_cnt;
    logic          load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign state = state_q;

    // FSM and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drain_cnt   <= '0;
            step_done   <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            step_done <= (state_q == S_STEP);
            if (pipe_en)
                cycle_count <= sat_inc(cycle_count);
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd == CMD_RUN)
                        state_q <= S_RUN;
                    else if (cmd_valid && cmd == CMD_STEP)
                        state_q <= S_STEP;
                end
                S_RUN: begin
                    // A debugger halt wins; the HALT opcode stays in IF/ID and is seen again on resume.
                    if (cmd_valid && cmd == CMD_HALT)
                        state_q <= S_IDLE;
                    else if (halt_instr && !branch_taken) begin
                        state_q   <= S_DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end
                end
                S_STEP: state_q <= S_IDLE;
                S_DRAIN: begin
                    if (branch_taken)
                        state_q <= S_RUN;
                    else if (drain_cnt == '0) begin
                        state_q <= S_HALTED;
                        halted  <= 1'b1;
                    end else
                        drain_cnt <= drain_cnt - 1'b1;
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign load_use = id_ex_MemRead && (id_ex_rt != '0) &&
                      ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // Zero-latency enable/flush decode
    always_comb begin
        pipe_en      = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
        pc_write     = pipe_en;
        if_id_write  = pipe_en;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (pipe_en && branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (state_q == S_DRAIN) begin
            // Feed NOPs behind the HALT while older instructions retire.
            pc_write    = 1'b0;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
        end else if (pipe_en && load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: hazard decode table in RUN plus step/drain/halt/reset sequences.
module tb_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        halt_instr;
    logic        id_ex_MemRead;
    logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
    logic        branch_taken;
    logic        pipe_en, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic        step_done, halted;
    logic [2:0]  state;
    logic [31:0] cycle_count;
    logic        s_pipe_en, s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
    logic        s_step_done, s_halted;
    logic [2:0]  s_state;
    logic [1:0]  s_cycle_count;

    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipeline_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .halt_instr(halt_instr), .id_ex_MemRead(id_ex_MemRead), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken),
        .pipe_en(pipe_en), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .step_done(step_done), .halted(halted), .state(state), .cycle_count(cycle_count)
    );

    // Narrow-counter instance to exercise saturation.
    pipeline_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .halt_instr(halt_instr), .id_ex_MemRead(id_ex_MemRead), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken),
        .pipe_en(s_pipe_en), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
        .step_done(s_step_done), .halted(s_halted), .state(s_state), .cycle_count(s_cycle_count)
    );

    typedef struct {
        logic       mr;
        logic [4:0] ex_rt, rs, rt;
        logic       br;
        logic [4:0] exp; // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        cmd_valid = 0; cmd = 0; halt_instr = 0; id_ex_MemRead = 0;
        id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0; branch_taken = 0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11000};
        vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'b00010};
        vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'b11000};
        vecs[3] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 5'b00010};
        vecs[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 5'b11000};
        vecs[5] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 5'b11111};
        vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'b11111};
        vecs[7] = '{1'b1, 5'd3, 5'd4, 5'd6, 1'b0, 5'b11000};

        clear_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_pipe_en", 32'(pipe_en), 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_step_done", 32'(step_done), 0);
        chk("rst_pc_write", 32'(pc_write), 0);
        reset = 0;

        // Single step from IDLE
        cmd_valid = 1; cmd = 2'b10;
        @(negedge clk);
        cmd_valid = 0; #1;
        chk("step_state", 32'(state), 2);
        chk("step_pipe_en", 32'(pipe_en), 1);
        @(negedge clk); exp_cnt++; #1;
        chk("step_back_idle", 32'(state), 0);
        chk("step_done_pulse", 32'(step_done), 1);
        chk("step_pipe_en_off", 32'(pipe_en), 0);
        chk("step_cycle_count", cycle_count, 1);
        @(negedge clk); #1;
        chk("step_done_clear", 32'(step_done), 0);

        // Enter RUN and apply hazard table
        cmd_valid = 1; cmd = 2'b01;
        @(negedge clk);
        cmd_valid = 0; #1;
        chk("run_state", 32'(state), 1);
        for (int i = 0; i < 8; i++) begin
            id_ex_MemRead = vecs[i].mr; id_ex_rt = vecs[i].ex_rt;
            if_id_rs = vecs[i].rs; if_id_rt = vecs[i].rt; branch_taken = vecs[i].br;
            #1;
            chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(vecs[i].exp[4]));
            chk($sformatf("v%0d_if_id_write", i), 32'(if_id_write), 32'(vecs[i].exp[3]));
            chk($sformatf("v%0d_if_id_flush", i), 32'(if_id_flush), 32'(vecs[i].exp[2]));
            chk($sformatf("v%0d_id_ex_flush", i), 32'(id_ex_flush), 32'(vecs[i].exp[1]));
            chk($sformatf("v%0d_ex_mem_flush", i), 32'(ex_mem_flush), 32'(vecs[i].exp[0]));
            @(negedge clk); exp_cnt++;
        end
        clear_inputs();

        // HALT drain: four DRAIN cycles with load_use present but ignored
        halt_instr = 1;
        @(negedge clk); exp_cnt++;
        halt_instr = 0; id_ex_MemRead = 1; id_ex_rt = 5; if_id_rs = 5;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("drain%0d_state", i), 32'(state), 3);
            chk($sformatf("drain%0d_pc_write", i), 32'(pc_write), 0);
            chk($sformatf("drain%0d_if_id_flush", i), 32'(if_id_flush), 1);
            chk($sformatf("drain%0d_if_id_write", i), 32'(if_id_write), 1);
            chk($sformatf("drain%0d_id_ex_flush", i), 32'(id_ex_flush), 0);
            @(negedge clk); exp_cnt++;
        end
        clear_inputs(); #1;
        chk("halted_state", 32'(state), 4);
        chk("halted_flag", 32'(halted), 1);
        chk("halted_pipe_en", 32'(pipe_en), 0);
        chk("halted_pc_write", 32'(pc_write), 0);
        chk("halted_cycle_count", cycle_count, 32'(exp_cnt));
        chk("sat_cycle_count", 32'(s_cycle_count), 3);
        cmd_valid = 1; cmd = 2'b01;
        @(negedge clk);
        cmd_valid = 0; #1;
        chk("halted_ignores_run", 32'(state), 4);
        chk("halted_stays_frozen", 32'(pipe_en), 0);

        // Branch aborts a drain
        reset = 1;
        @(negedge clk);
        reset = 0; #1;
        chk("rst2_state", 32'(state), 0);
        chk("rst2_cycle_count", cycle_count, 0);
        chk("rst2_halted", 32'(halted), 0);
        cmd_valid = 1; cmd = 2'b01;
        @(negedge clk);
        cmd_valid = 0; halt_instr = 1;
        @(negedge clk);
        halt_instr = 0; #1;
        chk("abort_drain1", 32'(state), 3);
        @(negedge clk);
        branch_taken = 1; #1;
        chk("abort_drain2", 32'(state), 3);
        chk("abort_pc_write", 32'(pc_write), 1);
        chk("abort_if_id_flush", 32'(if_id_flush), 1);
        chk("abort_ex_mem_flush", 32'(ex_mem_flush), 1);
        @(negedge clk);
        branch_taken = 0; #1;
        chk("abort_to_run", 32'(state), 1);

        // Halt command has priority over halt_instr
        cmd_valid = 1; cmd = 2'b11; halt_instr = 1;
        @(negedge clk);
        clear_inputs(); #1;
        chk("halt_cmd_idle", 32'(state), 0);
        chk("halt_cmd_pipe_en", 32'(pipe_en), 0);

        // Reset in the middle of a step
        cmd_valid = 1; cmd = 2'b10;
        @(negedge clk);
        cmd_valid = 0; #1;
        chk("mid_step_state", 32'(state), 2);
        reset = 1;
        @(negedge clk);
        reset = 0; #1;
        chk("mid_step_rst_state", 32'(state), 0);
        chk("mid_step_no_done", 32'(step_done), 0);
        @(negedge clk); #1;
        chk("mid_step_no_done_late", 32'(step_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
